mux_sel_arbiter: RTL and testbench
==================================

Name: mux_sel_arbiter

Overview:
- Upstream stage for the 2:1 mux. Merges two valid/ready input streams (channel A, channel B) into one registered output stream.
- Drives `sel` using the mux convention: sel=1 selects a, sel=0 selects b. `sel` always identifies the channel that owns the word currently in the output register.
- Burst-limited round-robin arbitration. One word per cycle sustained throughput.

Parameters:
- WIDTH, 1, data width of a_data, b_data and y_data.
- MAX_BURST, 4, maximum consecutive grants to one channel while the other channel is requesting. Legal range is at least 1; 1 gives strict alternation.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- a_valid  input  1  channel A word available.
- a_data  input  WIDTH  channel A word.
- a_ready  output  1  channel A word accepted this cycle.
- b_valid  input  1  channel B word available.
- b_data  input  WIDTH  channel B word.
- b_ready  output  1  channel B word accepted this cycle.
- y_valid  output  1  output register holds a word.
- y_data  output  WIDTH  output word.
- y_ready  input  1  downstream accepts the output word.
- sel  output  1  owner of the output word (1 = A, 0 = B); feeds the mux select.

Behaviour:
- Clock and reset: single clock `clk`. Reset `rst_n` is synchronous and active-low.
- Reset values (rst_n=0 at a clock edge): y_valid=0, y_data=0, sel=0, state=IDLE, burst count cnt=0.
- Ready during reset: a_ready and b_ready are 0 whenever rst_n=0, regardless of other inputs.
- Reset mid-operation: discards the held output word and any burst history.
- Handshake:
  - A transfer occurs on a cycle where x_valid and x_ready are both 1.
  - Inputs may hold valid indefinitely. x_data must be stable while x_valid=1 and x_ready=0.
- Load enable: load_en = !y_valid || y_ready, computed combinationally.
  - a_ready = load_en && grant_a; b_ready = load_en && grant_b.
  - A combinational path from y_ready to a_ready/b_ready is permitted.
  - At most one of a_ready and b_ready is 1 in any cycle.
- State machine:
  - States: IDLE (no transfer since reset), OWN_A, OWN_B. State records the channel of the last accepted word.
  - IDLE: A alone → grant A. B alone → grant B. Both → grant A.
  - OWN_X, only X valid → grant X.
  - OWN_X, only the other channel valid → grant the other channel.
  - OWN_X, both valid: grant X if cnt < MAX_BURST, otherwise grant the other channel.
  - Neither valid → no grant; state and cnt are unchanged.
- Burst counter:
  - On a transfer from the same channel as the state: cnt = cnt + 1, saturating at MAX_BURST.
  - On a transfer from a different channel, or from IDLE: cnt = 1, and state moves to the granted channel.
  - cnt width is clog2(MAX_BURST+1).
  - A lone requester is never throttled. Saturation only matters when both channels request.
- Output register, on a transfer:
  - y_data ← granted data; y_valid ← 1; sel ← 1 if A was granted, else 0.
  - Latency is one cycle from input handshake to y_valid.
- Output register, when load_en=1 and there is no transfer: y_valid ← 0; y_data and sel hold their last values.
- Output register, when load_en=0 (y_valid=1, y_ready=0): y_valid, y_data and sel hold. No input is accepted.
- Simultaneous events: an output drain (y_ready=1) and a new load in the same cycle are legal. This gives back-to-back words with no bubble.
- Invariant: y_valid=0 implies that y_ready has no effect.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with a_valid=b_valid=1 and y_ready=1 → a_ready=b_ready=0, y_valid=0, sel=0, y_data=0 throughout.
- Single stream: A sends 5,6,7,8,9,10 (WIDTH=8), B idle, y_ready=1 → y_data=5..10 on consecutive cycles, each one cycle after acceptance; sel=1; no gaps after cnt saturates at 4.
- Fair burst: both channels valid continuously, MAX_BURST=4, y_ready=1 → grant pattern AAAABBBBAAAA; sel is 1,1,1,1,0,0,0,0,1,1,1,1 one cycle later.
- Backpressure: y_valid=1, y_data=0x3C, y_ready=0 for 3 cycles with both inputs valid → y_data holds 0x3C, sel holds, a_ready=b_ready=0. With y_ready=1 on cycle 4 → the next word loads that cycle, with no bubble.
- Reset mid-burst: after 2 A grants with both valid, pulse rst_n=0 for 1 cycle → y_valid=0. The first grant after reset is A (IDLE tie) with cnt=1, and A then gets 4 grants before the switch to B.
- Strict alternation: MAX_BURST=1, both valid, y_ready=1 → grants ABABAB. With B idle → AAAA (no throttling).

Source files
------------

// File: rtl/mux_sel_arbiter.sv
// Two-channel valid/ready merger feeding a 2:1 mux: burst-limited round-robin
// arbitration into a single registered output word; sel names the word's owner.
module mux_sel_arbiter #(
  parameter int WIDTH     = 1,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             y_valid,
  output logic [WIDTH-1:0] y_data,
  input  logic             y_ready,
  output logic             sel
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] OWN_A = 2'd1;
  localparam logic [1:0] OWN_B = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          grant_a;
  logic          grant_b;
  logic          load_en;
  logic          burst_open;

  assign burst_open = (cnt < CNT_MAX);
  assign load_en    = !y_valid || y_ready;

  // The current owner keeps the grant only while the burst budget lasts and
  // the other side is also asking; a lone requester always wins.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    case (state)
      OWN_A: begin
        if (a_valid && b_valid) begin
          grant_a = burst_open;
          grant_b = !burst_open;
        end else begin
          grant_a = a_valid;
          grant_b = b_valid;
        end
      end
      OWN_B: begin
        if (a_valid && b_valid) begin
          grant_b = burst_open;
          grant_a = !burst_open;
        end else begin
          grant_a = a_valid;
          grant_b = b_valid;
        end
      end
      default: begin
        grant_a = a_valid;
        grant_b = b_valid && !a_valid;
      end
    endcase
  end

  assign a_ready = rst_n && load_en && grant_a;
  assign b_ready = rst_n && load_en && grant_b;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      y_valid <= 1'b0;
      y_data  <= '0;
      sel     <= 1'b0;
    end else if (load_en) begin
      if (a_ready) begin
        y_valid <= 1'b1;
        y_data  <= a_data;
        sel     <= 1'b1;
        if (state == OWN_A) begin
          if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
        end else begin
          state <= OWN_A;
          cnt   <= CW'(1);
        end
      end else if (b_ready) begin
        y_valid <= 1'b1;
        y_data  <= b_data;
        sel     <= 1'b0;
        if (state == OWN_B) begin
          if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
        end else begin
          state <= OWN_B;
          cnt   <= CW'(1);
        end
      end else begin
        y_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Directed bench for mux_sel_arbiter: a MAX_BURST=4 and a MAX_BURST=1 instance
// share the same input stimulus; expected grants and words are hand-derived.
module tb_mux_sel_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a_valid;
  logic [7:0] a_data;
  logic       b_valid;
  logic [7:0] b_data;
  logic       y_ready;

  logic       a_ready4, b_ready4, y_valid4, sel4;
  logic [7:0] y_data4;
  logic       a_ready1, b_ready1, y_valid1, sel1;
  logic [7:0] y_data1;

  int checks = 0;
  int errors = 0;

  logic       exp_a;
  logic       exp_a1;
  logic [7:0] exp_word;
  logic [7:0] exp_word1;

  always #5 clk = ~clk;

  mux_sel_arbiter #(.WIDTH(8), .MAX_BURST(4)) d4 (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready4),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready4),
    .y_valid(y_valid4), .y_data(y_data4), .y_ready(y_ready), .sel(sel4)
  );

  mux_sel_arbiter #(.WIDTH(8), .MAX_BURST(1)) d1 (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready1),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready1),
    .y_valid(y_valid1), .y_data(y_data1), .y_ready(y_ready), .sel(sel1)
  );

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_byte(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    a_valid = 1'b1;
    b_valid = 1'b1;
    a_data  = 8'h11;
    b_data  = 8'h22;
    y_ready = 1'b1;

    // Reset held for two cycles with both channels requesting
    for (int i = 0; i < 2; i++) begin
      tick();
      check_bit("rst_a_ready", a_ready4, 1'b0);
      check_bit("rst_b_ready", b_ready4, 1'b0);
      check_bit("rst_y_valid", y_valid4, 1'b0);
      check_bit("rst_sel", sel4, 1'b0);
      check_byte("rst_y_data", y_data4, 8'h00);
      check_bit("rst_a_ready_mb1", a_ready1, 1'b0);
    end

    // Single stream on A: no throttling on either instance
    rst_n   = 1'b1;
    b_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      a_data = 8'(5 + i);
      #1;
      check_bit("single_a_ready", a_ready4, 1'b1);
      check_bit("single_b_ready", b_ready4, 1'b0);
      check_bit("single_a_ready_mb1", a_ready1, 1'b1);
      tick();
      check_bit("single_y_valid", y_valid4, 1'b1);
      check_byte("single_y_data", y_data4, 8'(5 + i));
      check_bit("single_sel", sel4, 1'b1);
      check_byte("single_y_data_mb1", y_data1, 8'(5 + i));
    end
    a_valid = 1'b0;
    tick();
    check_bit("drain_y_valid", y_valid4, 1'b0);
    check_byte("drain_y_data_hold", y_data4, 8'd10);
    check_bit("drain_sel_hold", sel4, 1'b1);

    // Fair burst from IDLE: AAAABBBBAAAA for MAX_BURST=4, ABAB... for MAX_BURST=1
    rst_n = 1'b0;
    tick();
    rst_n   = 1'b1;
    a_valid = 1'b1;
    b_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      a_data = 8'(8'hA0 + i);
      b_data = 8'(8'hB0 + i);
      exp_a  = ((i / 4) % 2) == 0;
      exp_a1 = (i % 2) == 0;
      exp_word  = exp_a  ? a_data : b_data;
      exp_word1 = exp_a1 ? a_data : b_data;
      #1;
      check_bit("fair_a_ready", a_ready4, exp_a);
      check_bit("fair_b_ready", b_ready4, !exp_a);
      check_bit("alt_a_ready", a_ready1, exp_a1);
      check_bit("alt_b_ready", b_ready1, !exp_a1);
      tick();
      check_bit("fair_sel", sel4, exp_a);
      check_byte("fair_y_data", y_data4, exp_word);
      check_bit("alt_sel", sel1, exp_a1);
      check_byte("alt_y_data", y_data1, exp_word1);
    end

    // Backpressure: A's burst is exhausted, so B's 0x3C is loaded next
    a_data = 8'h55;
    b_data = 8'h3C;
    tick();
    check_byte("bp_load_data", y_data4, 8'h3C);
    check_bit("bp_load_sel", sel4, 1'b0);
    check_byte("bp_load_data_mb1", y_data1, 8'h55);
    b_data  = 8'h66;
    y_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_bit("bp_a_ready", a_ready4, 1'b0);
      check_bit("bp_b_ready", b_ready4, 1'b0);
      tick();
      check_bit("bp_y_valid", y_valid4, 1'b1);
      check_byte("bp_y_data", y_data4, 8'h3C);
      check_bit("bp_sel", sel4, 1'b0);
    end
    y_ready = 1'b1;
    #1;
    check_bit("bp_release_b_ready", b_ready4, 1'b1);
    check_bit("bp_release_a_ready", a_ready4, 1'b0);
    tick();
    check_bit("bp_release_y_valid", y_valid4, 1'b1);
    check_byte("bp_release_y_data", y_data4, 8'h66);
    check_bit("bp_release_sel", sel4, 1'b0);

    // Reset mid-burst: history is dropped, A then gets a full burst of four
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      check_bit("mid_pre_a_ready", a_ready4, 1'b1);
      tick();
    end
    rst_n = 1'b0;
    #1;
    check_bit("mid_rst_a_ready", a_ready4, 1'b0);
    check_bit("mid_rst_b_ready", b_ready4, 1'b0);
    tick();
    check_bit("mid_rst_y_valid", y_valid4, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a_data = 8'(8'hC0 + i);
      b_data = 8'(8'hD0 + i);
      exp_a  = (i < 4);
      exp_word = exp_a ? a_data : b_data;
      #1;
      check_bit("mid_a_ready", a_ready4, exp_a);
      check_bit("mid_b_ready", b_ready4, !exp_a);
      tick();
      check_bit("mid_sel", sel4, exp_a);
      check_byte("mid_y_data", y_data4, exp_word);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
